// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Pulls words out of an upstream FIFO whose read data arrives one cycle after
// an accepted read, parks them in a 2-entry skid buffer and presents them on a
// valid/ready stream framed into PKT_LEN-word packets by m_last.
//
// Optional feature: define FIFO_RD_STREAMER_CNT_EN to add the word_cnt output
// (saturating 32-bit count of words handed downstream).
//
// Ports
//   clk_rd        single clock, all state changes on its rising edge
//   rd_rst        synchronous, active-high reset
//   fifo_empty    upstream FIFO empty flag (clk_rd domain)
//   fifo_rd_en    read request to the upstream FIFO
//   fifo_rd_data  upstream read data, valid the cycle after an accepted read
//   m_valid       m_data/m_last hold a word
//   m_ready       sink accepts the word
//   m_data        oldest buffered word
//   m_last        final word of the current packet
//   word_cnt      (FIFO_RD_STREAMER_CNT_EN only) saturating pop count
//
// Handshake: a word moves downstream in every cycle where m_valid && m_ready.
// Once m_valid rises it stays high, with m_data/m_last unchanged, until that
// transfer happens. A read is accepted upstream when fifo_rd_en && !fifo_empty.
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk_rd,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_RD_STREAMER_CNT_EN
    ,
    output logic [31:0]           word_cnt
`endif
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head (oldest word)
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [15:0]           beat_q, beat_d;

    logic       pop;
    logic       capture;
    logic       rd_fire;
    logic [2:0] committed;

    always_comb begin
        pop     = (occ_q != 2'd0) && m_ready;
        capture = inflight_q;

        // Slots already spoken for once this cycle's pop leaves. pop implies
        // occ_q >= 1, so this never underflows.
        committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rd_rst && !fifo_empty && (committed < 3'd2);
        rd_fire    = fifo_rd_en && !fifo_empty;

        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        unique case ({capture, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = fifo_rd_data;
                else               buf1_d = fifo_rd_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind whatever remains.
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end
            end
            default: ;
        endcase

        inflight_d = rd_fire;

        beat_d = beat_q;
        if (pop) beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
    end

    always_ff @(posedge clk_rd) begin
        if (rd_rst) begin
            // Clearing inflight_q drops any word still on its way from the FIFO.
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            beat_q     <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            beat_q     <= beat_d;
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign m_last  = (beat_q == LAST_BEAT);

`ifdef FIFO_RD_STREAMER_CNT_EN
    logic [31:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (pop && (word_cnt_q != 32'hFFFF_FFFF)) word_cnt_d = word_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_rd) begin
        if (rd_rst) word_cnt_q <= 32'd0;
        else        word_cnt_q <= word_cnt_d;
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer. Three instances share one input stream and
// differ only in PKT_LEN (4, 1, 3); an upstream FIFO model feeds them and a
// word-level reference model (list of words with the cycle each becomes
// visible) predicts every output.
module tb_fifo_rd_streamer;

    localparam int W = 32;

    logic         clk_rd = 1'b0;
    logic         rd_rst = 1'b1;
    logic         fifo_empty = 1'b1;
    logic         m_ready = 1'b0;
    logic [W-1:0] fifo_rd_data = '0;

    logic         rd_en4, rd_en1, rd_en3;
    logic         valid4, valid1, valid3;
    logic [W-1:0] data4, data1, data3;
    logic         last4, last1, last3;
`ifdef FIFO_RD_STREAMER_CNT_EN
    logic [31:0]  wc4, wc1, wc3;
`endif

    always #5 clk_rd = ~clk_rd;

    fifo_rd_streamer #(.DATA_WIDTH(W), .PKT_LEN(4)) dut4 (
        .clk_rd(clk_rd), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
        .fifo_rd_data(fifo_rd_data), .m_valid(valid4), .m_ready(m_ready), .m_data(data4),
        .m_last(last4)
`ifdef FIFO_RD_STREAMER_CNT_EN
        , .word_cnt(wc4)
`endif
    );
    fifo_rd_streamer #(.DATA_WIDTH(W), .PKT_LEN(1)) dut1 (
        .clk_rd(clk_rd), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en1),
        .fifo_rd_data(fifo_rd_data), .m_valid(valid1), .m_ready(m_ready), .m_data(data1),
        .m_last(last1)
`ifdef FIFO_RD_STREAMER_CNT_EN
        , .word_cnt(wc1)
`endif
    );
    fifo_rd_streamer #(.DATA_WIDTH(W), .PKT_LEN(3)) dut3 (
        .clk_rd(clk_rd), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en3),
        .fifo_rd_data(fifo_rd_data), .m_valid(valid3), .m_ready(m_ready), .m_data(data3),
        .m_last(last3)
`ifdef FIFO_RD_STREAMER_CNT_EN
        , .word_cnt(wc3)
`endif
    );

    // Upstream FIFO contents and reference model state.
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];      // words read, oldest first
    int           avail_q[$];    // cycle in which each word becomes visible
    int           cyc = 0;
    int           beats = 0;     // pops since the last reset
    int           fires = 0;     // accepted reads observed on the DUT
    int           total = 0;
    int           bad = 0;
    logic         armed = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_words(input logic [W-1:0] base, input int n, input logic rnd);
        for (int i = 0; i < n; i++) src_q.push_back(rnd ? W'($urandom) : base + W'(i));
    endtask

    // One clock cycle: drive inputs, check the cycle's outputs against the
    // model, then advance the model and the upstream FIFO across the edge.
    task automatic step(input logic rst, input logic rdy, input logic force_empty);
        int   buffered;
        int   inflight;
        logic exp_valid, exp_pop, exp_en, dut_fire;
        rd_rst     = rst;
        m_ready    = rdy;
        fifo_empty = force_empty || (src_q.size() == 0);
        #1;
        buffered = 0;
        inflight = 0;
        foreach (avail_q[i]) begin
            if (avail_q[i] <= cyc) buffered++;
            else if (avail_q[i] == cyc + 1) inflight++;
        end
        exp_valid = (buffered > 0);
        exp_pop   = exp_valid && rdy;
        exp_en    = !rst && !fifo_empty && ((buffered + inflight - (exp_pop ? 1 : 0)) < 2);

        check("rd_en4", W'(rd_en4), W'(exp_en));
        check("rd_en1", W'(rd_en1), W'(exp_en));
        check("rd_en3", W'(rd_en3), W'(exp_en));
        if (armed) begin
            check("valid4", W'(valid4), W'(exp_valid));
            check("valid1", W'(valid1), W'(exp_valid));
            check("valid3", W'(valid3), W'(exp_valid));
            if (exp_valid) begin
                check("data4", data4, exp_q[0]);
                check("data1", data1, exp_q[0]);
                check("data3", data3, exp_q[0]);
            end
            check("last4", W'(last4), W'((beats % 4) == 3));
            check("last1", W'(last1), W'(1'b1));
            check("last3", W'(last3), W'((beats % 3) == 2));
`ifdef FIFO_RD_STREAMER_CNT_EN
            check("word_cnt4", wc4, W'(beats));
            check("word_cnt3", wc3, W'(beats));
`endif
        end
        dut_fire = rd_en4 && !fifo_empty;

        @(posedge clk_rd);
        #1;
        if (rst) begin
            exp_q.delete();
            avail_q.delete();
            beats = 0;
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
                void'(avail_q.pop_front());
                beats++;
            end
            if (exp_en && !fifo_empty) begin
                exp_q.push_back(src_q[0]);
                avail_q.push_back(cyc + 2);
            end
        end
        if (dut_fire && src_q.size() > 0) begin
            fifo_rd_data = src_q.pop_front();
            fires++;
        end
        cyc++;
    endtask

    initial begin
        int f0;

        // Reset: outputs are unknown during the first reset cycle only.
        step(1'b1, 1'b1, 1'b0);
        armed = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("rst_data", data4, '0);
        check("rst_last4", W'(last4), '0);

        // Full-rate stream 0xA0.. : read in cycle 0, first word in cycle 2.
        push_words(W'(32'hA0), 16, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);

        // Sink stalls for 5 cycles, then resumes.
        repeat (5) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);

        // Single word, then the FIFO stays empty.
        f0 = fires;
        push_words(W'(32'h5A5A_0001), 1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        check("single_fire", W'(fires - f0), W'(1));

        // Reset with a full skid buffer.
        push_words(W'(32'hB0), 8, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rst_full_valid", W'(valid4), '0);
        check("rst_full_data", data4, '0);
        repeat (4) step(1'b0, 1'b1, 1'b0);

        // Reset while a read is in flight; that word must never appear.
        push_words(W'(32'hC0), 8, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("rst_flight_valid", W'(valid4), '0);
        repeat (14) step(1'b0, 1'b1, 1'b0);

        // Empty asserting with a word in flight.
        push_words(W'(32'hD0), 4, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b0);

        // Random traffic, backpressure, empty gaps and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() < 3) push_words('0, $urandom_range(1, 6), 1'b1);
            step($urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0);
        end
        repeat (10) step(1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
